// File: rtl/chip8_reg_mem_transfer_if.sv
// Bundle of CPU handshake, RAM port and register-file port 1 signals for the
// FX55/FX65 bulk transfer sequencer. The slave modport is the sequencer side;
// the master modport is the CPU/RAM/register-file side.
interface chip8_reg_mem_transfer_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic                  is_load;
  logic [3:0]            last_reg;
  logic [15:0]           index_reg;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_writedata;
  logic                  mem_WE;
  logic [7:0]            mem_readdata;
  logic [3:0]            rf_addr;
  logic [7:0]            rf_writedata;
  logic                  rf_WE;
  logic [7:0]            rf_readdata;
  logic [15:0]           I_out;
  logic                  I_WE;

  modport master (
    output start, is_load, last_reg, index_reg, mem_readdata, rf_readdata,
    input  busy, done, mem_addr, mem_writedata, mem_WE,
           rf_addr, rf_writedata, rf_WE, I_out, I_WE
  );

  modport slave (
    input  start, is_load, last_reg, index_reg, mem_readdata, rf_readdata,
    output busy, done, mem_addr, mem_writedata, mem_WE,
           rf_addr, rf_writedata, rf_WE, I_out, I_WE
  );
endinterface

// File: rtl/chip8_reg_mem_transfer.sv
// Chip-8 FX55 / FX65 sequencer: moves V0..VX to or from mem[I..I+X], one
// register at a time, through register-file port 1 and a single RAM port.
// Optional feature macro CHIP8_I_INCREMENT_EN: when defined, I is rewritten
// to I+X+1 in the DONE cycle (COSMAC VIP); otherwise I_out/I_WE stay 0.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | waiting for start; all outputs 0
// S_STORE     | write V[k] to mem[base+k], one register per cycle
// S_LOAD_ADDR | present mem address base+k
// S_LOAD_WAIT | extra read-latency cycles (MEM_READ_LATENCY > 1 only)
// S_LOAD_WR   | write returned RAM byte into V[k]
// S_DONE      | one-cycle done pulse, busy low
module chip8_reg_mem_transfer #(
  parameter int ADDR_WIDTH       = 12,
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic                    cpu_clk,
  input  logic                    reset,
  chip8_reg_mem_transfer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_LOAD_ADDR,
    S_LOAD_WAIT,
    S_LOAD_WR,
    S_DONE
  } state_t;

  // Loaded on entry to LOAD_WAIT; the wait state lasts WAIT_INIT+1 cycles.
  localparam logic [1:0] WAIT_INIT = 2'(MEM_READ_LATENCY - 2);

  state_t                state, state_next;
  logic [3:0]            k, k_next;
  logic [1:0]            wait_cnt, wait_next;
  logic [ADDR_WIDTH-1:0] base;
  logic [3:0]            last;
  logic                  latch;
  logic [ADDR_WIDTH-1:0] addr_k;
`ifdef CHIP8_I_INCREMENT_EN
  logic [15:0]           index_full;
`endif

  // Address arithmetic stays in ADDR_WIDTH bits so I+k wraps around RAM.
  assign addr_k = base + ADDR_WIDTH'(k);

  // State, register index, wait counter and the operands captured at start.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state    <= S_IDLE;
      k        <= '0;
      wait_cnt <= '0;
      base     <= '0;
      last     <= '0;
`ifdef CHIP8_I_INCREMENT_EN
      index_full <= '0;
`endif
    end else begin
      state    <= state_next;
      k        <= k_next;
      wait_cnt <= wait_next;
      if (latch) begin
        base <= bus.index_reg[ADDR_WIDTH-1:0];
        last <= bus.last_reg;
`ifdef CHIP8_I_INCREMENT_EN
        index_full <= bus.index_reg;
`endif
      end
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_next        = state;
    k_next            = k;
    wait_next         = wait_cnt;
    latch             = 1'b0;
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_writedata = '0;
    bus.mem_WE        = 1'b0;
    bus.rf_addr       = '0;
    bus.rf_writedata  = '0;
    bus.rf_WE         = 1'b0;
    bus.I_out         = '0;
    bus.I_WE          = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          latch      = 1'b1;
          k_next     = '0;
          state_next = bus.is_load ? S_LOAD_ADDR : S_STORE;
        end
      end
      S_STORE: begin
        bus.busy          = 1'b1;
        bus.rf_addr       = k;
        bus.mem_addr      = addr_k;
        bus.mem_writedata = bus.rf_readdata;
        bus.mem_WE        = 1'b1;
        if (k == last) state_next = S_DONE;
        else           k_next     = k + 4'd1;
      end
      S_LOAD_ADDR: begin
        bus.busy     = 1'b1;
        bus.mem_addr = addr_k;
        if (MEM_READ_LATENCY == 1) begin
          state_next = S_LOAD_WR;
        end else begin
          wait_next  = WAIT_INIT;
          state_next = S_LOAD_WAIT;
        end
      end
      S_LOAD_WAIT: begin
        bus.busy     = 1'b1;
        bus.mem_addr = addr_k;
        if (wait_cnt == 2'd0) state_next = S_LOAD_WR;
        else                  wait_next  = wait_cnt - 2'd1;
      end
      S_LOAD_WR: begin
        bus.busy         = 1'b1;
        bus.mem_addr     = addr_k;
        bus.rf_addr      = k;
        bus.rf_writedata = bus.mem_readdata;
        bus.rf_WE        = 1'b1;
        if (k == last) begin
          state_next = S_DONE;
        end else begin
          k_next     = k + 4'd1;
          state_next = S_LOAD_ADDR;
        end
      end
      S_DONE: begin
        bus.done   = 1'b1;
`ifdef CHIP8_I_INCREMENT_EN
        bus.I_WE   = 1'b1;
        bus.I_out  = index_full + 16'(last) + 16'd1;
`endif
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_chip8_reg_mem_transfer.sv
// Bench for chip8_reg_mem_transfer: behavioural RAM (MEM_READ_LATENCY-deep
// read pipeline) and register file, randomized transfers checked against a
// reference model of the FX55/FX65 rules. Honours CHIP8_I_INCREMENT_EN.
module tb_chip8_reg_mem_transfer;
  localparam int AW  = 12;
  localparam int LAT = 2;

  logic cpu_clk = 1'b0;
  logic reset;
  always #5 cpu_clk = ~cpu_clk;

  chip8_reg_mem_transfer_if #(.ADDR_WIDTH(AW)) bus();

  chip8_reg_mem_transfer #(.ADDR_WIDTH(AW), .MEM_READ_LATENCY(LAT)) dut (
    .cpu_clk(cpu_clk),
    .reset  (reset),
    .bus    (bus)
  );

  logic [7:0]  ram     [0:4095];
  logic [7:0]  rf      [0:15];
  logic [7:0]  rd_pipe [0:LAT-1];
  logic [7:0]  exp_ram [0:4095];
  logic [7:0]  exp_rf  [0:15];
  logic        bd_ram_we = 1'b0;
  logic        bd_rf_we  = 1'b0;
  logic [11:0] bd_addr   = '0;
  logic [7:0]  bd_data   = '0;

  assign bus.mem_readdata = rd_pipe[LAT-1];
  assign bus.rf_readdata  = rf[bus.rf_addr];

  // RAM: clocked write, read data valid LAT cycles after the address.
  always @(posedge cpu_clk) begin
    if (bus.mem_WE) ram[bus.mem_addr] <= bus.mem_writedata;
    else if (bd_ram_we) ram[bd_addr] <= bd_data;
    rd_pipe[0] <= ram[bus.mem_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Register file: clocked write on port 1, combinational read.
  always @(posedge cpu_clk) begin
    if (bus.rf_WE) rf[bus.rf_addr] <= bus.rf_writedata;
    else if (bd_rf_we) rf[bd_addr[3:0]] <= bd_data;
  end

  int checks = 0;
  int errors = 0;

  int mem_t[$], mem_a[$], mem_d[$], rf_t[$], rf_a[$], rf_d[$];
  int cap_done_n, cap_done_t, cap_busy_bad, cap_both_we, cap_post_bad;
  int cap_iwe_n, cap_iwe_t;
  logic [15:0] cap_iout;

  task automatic poke_ram(input logic [11:0] a, input logic [7:0] d);
    @(negedge cpu_clk);
    bd_ram_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge cpu_clk);
    bd_ram_we = 1'b0;
  endtask

  task automatic poke_rf(input logic [3:0] a, input logic [7:0] d);
    @(negedge cpu_clk);
    bd_rf_we = 1'b1; bd_addr = {8'd0, a}; bd_data = d;
    @(negedge cpu_clk);
    bd_rf_we = 1'b0;
  endtask

  // Issue one start and record every strobe with its cycle number (t=1 is
  // the first cycle after the start edge). Optionally holds start until done
  // or asserts reset after sampling cycle abort_t.
  task automatic run_xfer(input bit ld, input int x, input logic [15:0] idx,
                          input bit hold, input int abort_t, input int budget);
    int t;
    bit aborted;
    mem_t.delete(); mem_a.delete(); mem_d.delete();
    rf_t.delete();  rf_a.delete();  rf_d.delete();
    cap_done_n = 0; cap_done_t = -1; cap_busy_bad = 0; cap_both_we = 0;
    cap_post_bad = 0; cap_iwe_n = 0; cap_iwe_t = -1; cap_iout = '0;
    aborted = 1'b0;
    @(negedge cpu_clk);
    bus.start = 1'b1; bus.is_load = ld; bus.last_reg = 4'(x); bus.index_reg = idx;
    t = 0;
    while (t < budget) begin
      @(negedge cpu_clk);
      t++;
      if (bus.mem_WE && bus.rf_WE) cap_both_we++;
      if (cap_done_t >= 0 || aborted) begin
        if (bus.busy || bus.mem_WE || bus.rf_WE) cap_post_bad++;
      end else begin
        if (bus.mem_WE) begin mem_t.push_back(t); mem_a.push_back(int'(bus.mem_addr)); mem_d.push_back(int'(bus.mem_writedata)); end
        if (bus.rf_WE)  begin rf_t.push_back(t);  rf_a.push_back(int'(bus.rf_addr));   rf_d.push_back(int'(bus.rf_writedata));   end
        if (bus.busy === bus.done) cap_busy_bad++;
      end
      if (bus.done) begin
        cap_done_n++;
        if (cap_done_t < 0) cap_done_t = t;
      end
      if (bus.I_WE) begin cap_iwe_n++; cap_iwe_t = t; cap_iout = bus.I_out; end
      if (!hold || bus.done) bus.start = 1'b0;
      if (t == 1) begin
        bus.is_load   = 1'($urandom);
        bus.last_reg  = 4'($urandom);
        bus.index_reg = 16'($urandom);
      end
      if (abort_t > 0 && t == abort_t) begin reset = 1'b1; aborted = 1'b1; end
      if (abort_t > 0 && t == abort_t + 1) reset = 1'b0;
      if (cap_done_t >= 0 && t >= cap_done_t + 3) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1; bus.is_load = 1'b0; bus.last_reg = 4'd3; bus.index_reg = 16'h300;
    repeat (2) begin
      @(posedge cpu_clk);
      @(negedge cpu_clk);
      checks++;
      if ({bus.busy, bus.done, bus.mem_WE, bus.rf_WE, bus.I_WE} !== 5'b0) begin
        errors++; $display("FAIL reset_strobes: got %b want 00000", {bus.busy, bus.done, bus.mem_WE, bus.rf_WE, bus.I_WE});
      end
      checks++;
      if ({bus.mem_addr, bus.mem_writedata, bus.rf_addr, bus.rf_writedata, bus.I_out} !== '0) begin
        errors++; $display("FAIL reset_buses: got addr %h wd %h rfa %h rfwd %h I %h want all 0",
                           bus.mem_addr, bus.mem_writedata, bus.rf_addr, bus.rf_writedata, bus.I_out);
      end
    end
    reset = 1'b0; bus.start = 1'b0;
    repeat (2) @(negedge cpu_clk);
    checks++;
    if ({bus.busy, bus.done, bus.mem_WE} !== 3'b0) begin
      errors++; $display("FAIL reset_start_ignored: busy/done/mem_WE got %b want 000", {bus.busy, bus.done, bus.mem_WE});
    end
  endtask

  task automatic test_store();
    logic [7:0] vals [4];
    vals = '{8'd11, 8'd22, 8'd33, 8'd44};
    for (int k = 0; k < 4; k++) poke_rf(4'(k), vals[k]);
    run_xfer(1'b0, 3, 16'h300, 1'b0, 0, 40);
    checks++;
    if (mem_a.size() != 4) begin errors++; $display("FAIL store_count: got %0d want 4", mem_a.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < mem_a.size()) begin
        checks++;
        if (mem_t[k] != k + 1 || mem_a[k] != 'h300 + k || mem_d[k] != int'(vals[k])) begin
          errors++; $display("FAIL store_write%0d: got t%0d @%h=%0d want t%0d @%h=%0d",
                             k, mem_t[k], mem_a[k], mem_d[k], k + 1, 'h300 + k, vals[k]);
        end
      end
    end
    checks++;
    if (cap_done_t != 5 || cap_done_n != 1) begin
      errors++; $display("FAIL store_done: got t%0d n%0d want t5 n1", cap_done_t, cap_done_n);
    end
    checks++;
    if (cap_busy_bad != 0 || cap_post_bad != 0 || rf_a.size() != 0) begin
      errors++; $display("FAIL store_busy: got busy_bad %0d post_bad %0d rf_we %0d want 0 0 0",
                         cap_busy_bad, cap_post_bad, rf_a.size());
    end
    checks++;
    if (ram[12'h300] !== 8'd11 || ram[12'h301] !== 8'd22 || ram[12'h302] !== 8'd33 || ram[12'h303] !== 8'd44) begin
      errors++; $display("FAIL store_ram: got %0d %0d %0d %0d want 11 22 33 44",
                         ram[12'h300], ram[12'h301], ram[12'h302], ram[12'h303]);
    end
`ifdef CHIP8_I_INCREMENT_EN
    checks++;
    if (cap_iwe_n != 1 || cap_iwe_t != cap_done_t || cap_iout !== 16'h0304) begin
      errors++; $display("FAIL store_i_inc: got n%0d t%0d I=%h want n1 t%0d I=0304", cap_iwe_n, cap_iwe_t, cap_iout, cap_done_t);
    end
`else
    checks++;
    if (cap_iwe_n != 0) begin errors++; $display("FAIL store_no_iwe: got %0d pulses want 0", cap_iwe_n); end
`endif
  endtask

  task automatic test_load();
    poke_ram(12'h200, 8'hAA);
    poke_ram(12'h201, 8'hBB);
    run_xfer(1'b1, 1, 16'h200, 1'b0, 0, 60);
    checks++;
    if (rf_t.size() != 2) begin
      errors++; $display("FAIL load_count: got %0d want 2", rf_t.size());
    end else begin
      checks++;
      if (rf_t[0] != 1 + LAT || rf_t[1] != 2 * (1 + LAT)) begin
        errors++; $display("FAIL load_rf_we_times: got %0d %0d want %0d %0d", rf_t[0], rf_t[1], 1 + LAT, 2 * (1 + LAT));
      end
    end
    checks++;
    if (cap_done_t != 2 * (1 + LAT) + 1 || cap_done_n != 1) begin
      errors++; $display("FAIL load_done: got t%0d n%0d want t%0d n1", cap_done_t, cap_done_n, 2 * (1 + LAT) + 1);
    end
    checks++;
    if (rf[0] !== 8'hAA || rf[1] !== 8'hBB) begin
      errors++; $display("FAIL load_regs: got %h %h want aa bb", rf[0], rf[1]);
    end
    checks++;
    if (mem_a.size() != 0 || cap_both_we != 0 || cap_busy_bad != 0) begin
      errors++; $display("FAIL load_strobes: got mem_we %0d both %0d busy_bad %0d want 0 0 0",
                         mem_a.size(), cap_both_we, cap_busy_bad);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] v [4];
    for (int k = 0; k < 4; k++) begin
      v[k] = 8'($urandom);
      poke_rf(4'(k), v[k]);
    end
    run_xfer(1'b0, 3, 16'h0FFE, 1'b0, 0, 40);
    checks++;
    if (mem_a.size() != 4) begin
      errors++; $display("FAIL wrap_count: got %0d want 4", mem_a.size());
    end else begin
      checks++;
      if (mem_a[0] != 'hFFE || mem_a[1] != 'hFFF || mem_a[2] != 0 || mem_a[3] != 1) begin
        errors++; $display("FAIL wrap_addrs: got %h %h %h %h want ffe fff 0 1", mem_a[0], mem_a[1], mem_a[2], mem_a[3]);
      end
    end
    checks++;
    if (ram[12'hFFE] !== v[0] || ram[12'hFFF] !== v[1] || ram[12'h000] !== v[2] || ram[12'h001] !== v[3]) begin
      errors++; $display("FAIL wrap_ram: got %h %h %h %h want %h %h %h %h",
                         ram[12'hFFE], ram[12'hFFF], ram[12'h000], ram[12'h001], v[0], v[1], v[2], v[3]);
    end
  endtask

  task automatic test_load_x15();
    logic [15:0] idx;
    int bad;
    idx = 16'($urandom);
    for (int k = 0; k < 16; k++) poke_ram(12'(idx + 16'(k)), 8'($urandom));
    exp_ram = ram;
    run_xfer(1'b1, 15, idx, 1'b0, 0, 200);
    checks++;
    if (rf_a.size() != 16) begin
      errors++; $display("FAIL x15_pulses: got %0d want 16", rf_a.size());
    end else begin
      checks++;
      if (rf_a[15] != 15 || rf_t[15] != 16 * (1 + LAT)) begin
        errors++; $display("FAIL x15_vf_last: got reg %0d t%0d want reg 15 t%0d", rf_a[15], rf_t[15], 16 * (1 + LAT));
      end
    end
    bad = 0;
    for (int k = 0; k < 16; k++) if (rf[k] !== exp_ram[12'(idx + 16'(k))]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL x15_regs: got %0d wrong registers want 0", bad); end
    checks++;
    if (cap_done_t != 16 * (1 + LAT) + 1) begin
      errors++; $display("FAIL x15_done: got t%0d want t%0d", cap_done_t, 16 * (1 + LAT) + 1);
    end
  endtask

  task automatic test_start_held();
    int x;
    x = $urandom_range(0, 15);
    run_xfer(1'b0, x, 16'($urandom), 1'b1, 0, 60);
    checks++;
    if (cap_done_n != 1 || cap_done_t != x + 2) begin
      errors++; $display("FAIL held_one_done: got n%0d t%0d want n1 t%0d", cap_done_n, cap_done_t, x + 2);
    end
    checks++;
    if (cap_post_bad != 0 || mem_a.size() != x + 1) begin
      errors++; $display("FAIL held_no_restart: got post_bad %0d writes %0d want 0 %0d", cap_post_bad, mem_a.size(), x + 1);
    end
  endtask

  task automatic test_abort();
    int bad;
    for (int k = 0; k < 8; k++) poke_rf(4'(k), 8'($urandom));
    for (int k = 0; k < 8; k++) poke_ram(12'(16'h500 + 16'(k)), 8'($urandom));
    exp_ram = ram;
    for (int k = 0; k < 3; k++) exp_ram[12'(16'h500 + 16'(k))] = rf[k];
    run_xfer(1'b0, 7, 16'h0500, 1'b0, 3, 14);
    checks++;
    if (mem_a.size() != 3 || cap_done_n != 0) begin
      errors++; $display("FAIL abort_writes: got writes %0d done %0d want 3 0", mem_a.size(), cap_done_n);
    end
    checks++;
    if (cap_post_bad != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", cap_post_bad); end
    bad = 0;
    for (int k = 0; k < 8; k++) if (ram[12'(16'h500 + 16'(k))] !== exp_ram[12'(16'h500 + 16'(k))]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_ram: got %0d wrong bytes want 0", bad); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      bit ld, hold;
      int x, exp_done, bad_t, bad_m;
      logic [15:0] idx;
      ld = 1'($urandom); hold = 1'($urandom);
      x = $urandom_range(0, 15); idx = 16'($urandom);
      for (int k = 0; k <= x; k++) begin
        if (ld) poke_ram(12'(idx + 16'(k)), 8'($urandom));
        else    poke_rf(4'(k), 8'($urandom));
      end
      exp_ram = ram; exp_rf = rf;
      for (int k = 0; k <= x; k++) begin
        if (ld) exp_rf[k] = ram[12'(idx + 16'(k))];
        else    exp_ram[12'(idx + 16'(k))] = rf[k];
      end
      exp_done = ld ? (x + 1) * (1 + LAT) + 1 : x + 2;
      run_xfer(ld, x, idx, hold, 0, 120);
      checks++;
      if (cap_done_t != exp_done || cap_done_n != 1) begin
        errors++; $display("FAIL rand%0d_done: got t%0d n%0d want t%0d n1", n, cap_done_t, cap_done_n, exp_done);
      end
      checks++;
      if ((ld ? rf_a.size() : mem_a.size()) != x + 1 || (ld ? mem_a.size() : rf_a.size()) != 0) begin
        errors++; $display("FAIL rand%0d_strobes: got mem %0d rf %0d want %0d of kind load=%0d",
                           n, mem_a.size(), rf_a.size(), x + 1, ld);
      end
      bad_t = 0;
      for (int j = 0; j < mem_a.size(); j++)
        if (mem_t[j] != j + 1 || mem_a[j] != int'(12'(idx + 16'(j)))) bad_t++;
      for (int j = 0; j < rf_a.size(); j++)
        if (rf_t[j] != (j + 1) * (1 + LAT) || rf_a[j] != j) bad_t++;
      checks++;
      if (bad_t != 0) begin errors++; $display("FAIL rand%0d_timing: got %0d misplaced strobes want 0", n, bad_t); end
      bad_m = 0;
      for (int a = 0; a < 4096; a++) if (ram[a] !== exp_ram[a]) bad_m++;
      for (int r = 0; r < 16; r++) if (rf[r] !== exp_rf[r]) bad_m++;
      checks++;
      if (bad_m != 0) begin errors++; $display("FAIL rand%0d_contents: got %0d wrong cells want 0", n, bad_m); end
      checks++;
      if (cap_busy_bad != 0 || cap_both_we != 0 || cap_post_bad != 0) begin
        errors++; $display("FAIL rand%0d_handshake: got busy_bad %0d both %0d post %0d want 0 0 0",
                           n, cap_busy_bad, cap_both_we, cap_post_bad);
      end
`ifdef CHIP8_I_INCREMENT_EN
      checks++;
      if (cap_iwe_n != 1 || cap_iwe_t != cap_done_t || cap_iout !== 16'(idx + 16'(x) + 16'd1)) begin
        errors++; $display("FAIL rand%0d_i_inc: got n%0d t%0d I=%h want n1 t%0d I=%h",
                           n, cap_iwe_n, cap_iwe_t, cap_iout, cap_done_t, 16'(idx + 16'(x) + 16'd1));
      end
`else
      checks++;
      if (cap_iwe_n != 0) begin errors++; $display("FAIL rand%0d_no_iwe: got %0d pulses want 0", n, cap_iwe_n); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wrap();
    test_load_x15();
    test_start_held();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
